// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result/flag stage with a 2-entry skid buffer.
// Optional sticky overflow flag is built only when ALU_STICKY_OVF_EN is defined.
module alu_result_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_f,
  input  logic [3:0]       in_sel,
  input  logic             in_cout_msb,
  input  logic             in_cin_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_z,
  output logic             out_n,
  output logic             out_c,
  output logic             out_v,
  input  logic             clr_sticky,
  output logic             sticky_v
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Each stored beat is {f, z, n, c, v}.
  localparam int BW = WIDTH + 4;

  state_t        state_q, state_d;
  logic [BW-1:0] main_q, main_d;
  logic [BW-1:0] skid_q, skid_d;
  logic [BW-1:0] in_beat;
  logic          accept;
  logic          pop;
  logic          arith;
  logic          flag_z;
  logic          flag_n;
  logic          flag_c;
  logic          flag_v;
  logic [1:0]    sel_lo_unused;

  assign sel_lo_unused = in_sel[1:0];

  // Carry and overflow only mean something for the add/sub group.
  always_comb begin
    arith   = (in_sel[3:2] == 2'b00);
    flag_z  = (in_f == '0);
    flag_n  = in_f[WIDTH-1];
    flag_c  = arith & in_cout_msb;
    flag_v  = arith & (in_cin_msb ^ in_cout_msb);
    in_beat = {in_f, flag_z, flag_n, flag_c, flag_v};
  end

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_beat;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_d = in_beat;
        end else if (accept) begin
          skid_d  = in_beat;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_f = main_q[BW-1:4];
  assign out_z = main_q[3];
  assign out_n = main_q[2];
  assign out_c = main_q[1];
  assign out_v = main_q[0];

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // A new overflow beat beats a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky) begin
      sticky_d = 1'b0;
    end
    if (accept && flag_v) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_v = sticky_q;
`else
  logic clr_sticky_unused;

  assign clr_sticky_unused = clr_sticky;
  assign sticky_v          = 1'b0;
`endif

endmodule
